// File: rtl/exception_ctrl.sv
// Exception/interrupt resolver at the MEM/commit boundary: commits to CP0, flushes, then redirects fetch.
// Optional build macro EXC_INT_SYNC_EN adds a 2-flop synchronizer on int_i.
module exception_ctrl #(
  parameter int                      NUM_SRC      = 6,
  parameter int                      NUM_INT      = 6,
  parameter logic [NUM_SRC*5-1:0]    EXC_CODES    = {5'd5, 5'd12, 5'd8, 5'd9, 5'd10, 5'd4},
  parameter logic [NUM_SRC-1:0]      ADDR_SRC_MSK = 6'b100001,
  parameter logic [31:0]             EXC_VECTOR   = 32'hBFC00380,
  parameter int                      FLUSH_CYCLES = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               inst_valid_i,
  input  logic [31:0]        pc_i,
  input  logic               in_delay_slot_i,
  input  logic [31:0]        badvaddr_i,
  input  logic [NUM_SRC-1:0] exc_vec_i,
  input  logic               eret_i,
  input  logic [NUM_INT-1:0] int_i,
  input  logic [31:0]        cp0_status_i,
  input  logic [31:0]        cp0_cause_i,
  input  logic [31:0]        cp0_epc_i,
  output logic               stall_o,
  output logic               flush_o,
  output logic               exc_commit_o,
  output logic [4:0]         exc_code_o,
  output logic [31:0]        epc_o,
  output logic               bd_o,
  output logic               badvaddr_we_o,
  output logic [31:0]        badvaddr_o,
  output logic               eret_commit_o,
  output logic               redirect_valid_o,
  output logic [31:0]        redirect_pc_o,
  input  logic               redirect_ready_i
);

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT} state_t;

  state_t       r_state;
  logic [3:0]   r_flush_cnt;
  logic [31:0]  r_target;
  logic         r_flush, r_exc_commit, r_eret_commit, r_bd, r_badvaddr_we, r_redirect_valid;
  logic [4:0]   r_exc_code;
  logic [31:0]  r_epc, r_badvaddr, r_redirect_pc;

  logic [NUM_INT-1:0] w_int;
  logic [NUM_INT+1:0] w_ip;
  logic               w_int_pend;
  logic               w_exc_any;
  logic [4:0]         w_src_code;
  logic               w_src_addr;
  logic               w_src_fetch;

`ifdef EXC_INT_SYNC_EN
  logic [NUM_INT-1:0] r_int_s1, r_int_s2;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_int_s1 <= '0;
      r_int_s2 <= '0;
    end else begin
      r_int_s1 <= int_i;
      r_int_s2 <= r_int_s1;
    end
  end

  assign w_int = r_int_s2;
`else
  assign w_int = int_i;
`endif

  // Software IP bits sit below the hardware lines, matching Cause.IP[7:0] against Status.IM.
  assign w_ip       = {w_int, cp0_cause_i[9:8]};
  assign w_int_pend = inst_valid_i && (|(w_ip & cp0_status_i[NUM_INT+9:8]))
                      && !cp0_status_i[1] && cp0_status_i[0];
  assign w_exc_any  = |exc_vec_i;

  // NOTE: every variable gets a default before the loop so no latch is inferred.
  always_comb begin
    w_src_code  = '0;
    w_src_addr  = 1'b0;
    w_src_fetch = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (exc_vec_i[i]) begin
        w_src_code  = EXC_CODES[5*i +: 5];
        w_src_addr  = ADDR_SRC_MSK[i];
        w_src_fetch = (i == 0);
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every branch sees pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state          <= S_IDLE;
      r_flush_cnt      <= '0;
      r_target         <= '0;
      r_flush          <= 1'b0;
      r_exc_commit     <= 1'b0;
      r_eret_commit    <= 1'b0;
      r_exc_code       <= '0;
      r_epc            <= '0;
      r_bd             <= 1'b0;
      r_badvaddr_we    <= 1'b0;
      r_badvaddr       <= '0;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (inst_valid_i && (w_int_pend || w_exc_any)) begin
            r_exc_commit  <= 1'b1;
            r_exc_code    <= w_int_pend ? 5'd0 : w_src_code;
            r_epc         <= in_delay_slot_i ? pc_i - 32'd4 : pc_i;
            r_bd          <= in_delay_slot_i;
            r_badvaddr_we <= !w_int_pend && w_src_addr;
            if (!w_int_pend && w_src_addr)
              r_badvaddr <= w_src_fetch ? pc_i : badvaddr_i;
            r_target      <= EXC_VECTOR;
            r_flush       <= 1'b1;
            r_flush_cnt   <= 4'd1;
            r_state       <= S_FLUSH;
          end else if (inst_valid_i && eret_i) begin
            r_eret_commit <= 1'b1;
            r_target      <= cp0_epc_i;
            r_flush       <= 1'b1;
            r_flush_cnt   <= 4'd1;
            r_state       <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_exc_commit  <= 1'b0;
          r_eret_commit <= 1'b0;
          r_badvaddr_we <= 1'b0;
          if (r_flush_cnt == 4'(FLUSH_CYCLES)) begin
            r_flush          <= 1'b0;
            r_flush_cnt      <= '0;
            r_redirect_valid <= 1'b1;
            r_redirect_pc    <= r_target;
            r_state          <= S_REDIRECT;
          end else begin
            r_flush_cnt <= r_flush_cnt + 4'd1;
          end
        end
        S_REDIRECT: begin
          if (redirect_ready_i) begin
            r_redirect_valid <= 1'b0;
            r_state          <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall_o          = (r_state != S_IDLE);
  assign flush_o          = r_flush;
  assign exc_commit_o     = r_exc_commit;
  assign exc_code_o       = r_exc_code;
  assign epc_o            = r_epc;
  assign bd_o             = r_bd;
  assign badvaddr_we_o    = r_badvaddr_we;
  assign badvaddr_o       = r_badvaddr;
  assign eret_commit_o    = r_eret_commit;
  assign redirect_valid_o = r_redirect_valid;
  assign redirect_pc_o    = r_redirect_pc;

endmodule
